hazard_scheduler: RTL and testbench
===================================

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 The block SHALL have parameter WB_DIST, default 2, giving the minimum issue distance in cycles from a register writer to its reader; legal values are 1..3.
REQ-002 The block SHALL have parameter BR_LAT, default 2, giving the number of cycles issue is blocked after a branch issues; legal values are 1..3.
REQ-003 The block SHALL have the following ports, in this order:
- clk1  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  an instruction is present in ID.
- id_instr  in  32  the ID instruction: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- issue  out  1  the ID instruction advances to EX this cycle.
- stall  out  1  id_valid and not issue.
- halted  out  1  HLT has issued.
- stall_count  out  16  count of stall cycles.

Function
REQ-004 Decode SHALL classify the opcode as follows:
- RR ALU: 000000-000101; reads rs and rt; writes rd.
- ADDI/SUBI/SLTI: 001010-001100; reads rs; writes rt.
- LW: 001000; reads rs; writes rt.
- SW: 001001; reads rs and rt; no write.
- BNEQZ/BEQZ: 001101/001110; reads rs; no write.
- HLT: 111111; no reads, no writes.
- Any other opcode: no reads, no writes; issues freely.
REQ-005 The scoreboard SHALL hold a 2-bit pend[r] counter for each r in 1..31; R0 SHALL never be pending, and reads or writes of R0 SHALL be ignored.
REQ-006 A hazard SHALL exist when any register the ID instruction reads has pend != 0.
REQ-007 The issue output SHALL be combinational: issue = id_valid & ~hazard & ~halted & (br_cnt == 0).
REQ-008 When an instruction issues and writes Rw != 0, pend[Rw] SHALL be loaded with WB_DIST-1 on the next edge.
REQ-009 On every edge, every nonzero pend not being loaded SHALL decrement by 1; a load SHALL take priority over a decrement of the same entry.
REQ-010 With WB_DIST=2, a writer issued in cycle t SHALL allow a dependent reader to issue no earlier than cycle t+2 (one bubble); with WB_DIST=1, the reader SHALL issue at t+1.
REQ-011 When a branch issues, br_cnt SHALL load BR_LAT on the next edge and decrement to 0; issue SHALL be blocked while br_cnt != 0.
REQ-012 When HLT issues, halted SHALL be set on the next edge and SHALL stay set until reset; after that, issue SHALL be 0 and stall SHALL equal id_valid.
REQ-013 Issuing HLT SHALL NOT clear pending entries; they SHALL continue to decrement.
REQ-014 stall_count SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-015 If id_valid=0, issue and stall SHALL both be 0 and state SHALL only decrement.
REQ-016 When the same register is both read and written by the ID instruction and is not pending, the instruction SHALL issue and the register SHALL then become pending.
REQ-017 When a pending register is re-written, the load SHALL restart its count (WAW).

Reset
REQ-018 While rst_n=0, all pend entries, br_cnt, halted and stall_count SHALL be 0, asynchronously; issue and stall SHALL follow REQ-007 from the cleared state.
REQ-019 Reset asserted mid-operation SHALL discard all pending hazards and the halt; the first edge after release SHALL operate on the cleared state.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios, with WB_DIST=2 and BR_LAT=2 unless stated:
- Back-to-back independent: 2801000a then 28020014 then 28030019 -> three consecutive issue=1; stall_count=0.
- RAW one bubble: 2801000a in cycle 0, then 00222000 held valid -> stall=1 in cycle 1, issue=1 in cycle 2; stall_count=1.
- Dummy gap: 00222000, then 0ce77800, then 00832800 -> all issue with no stall (R4 at distance 2).
- WB_DIST=3 rerun of the RAW case -> two stall cycles; stall_count=2.
- Branch: 3420xxxx issues, then an independent instruction held valid -> stalled 2 cycles.
- Halt: fc000000 issues, then any id_valid=1 -> halted=1, issue=0, stall=1 and stall_count increments; rst_n pulse -> halted=0, stall_count=0, pend cleared; a RAW-free instruction issues on the next cycle.
- R0: 28000005 (ADDI R0) followed by a reader of R0 -> no stall.

Source files
------------

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - in-order issue scoreboard with RAW, branch-shadow and halt interlocks
module hazard_scheduler #(
    parameter int WB_DIST = 2,
    parameter int BR_LAT  = 2
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        issue,
    output logic        stall,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam logic [1:0] WB_LOAD = 2'(WB_DIST - 1);
    localparam logic [1:0] BR_LOAD = 2'(BR_LAT);

    logic [1:0]  pend_q [32];
    logic [1:0]  pend_d [32];
    logic [1:0]  br_cnt_q, br_cnt_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, wr_reg;
    logic        rd_rs, rd_rt, wr_en, is_br, is_hlt, hazard;
    logic        unused_low;

    assign op         = id_instr[31:26];
    assign rs         = id_instr[25:21];
    assign rt         = id_instr[20:16];
    assign rd         = id_instr[15:11];
    assign unused_low = ^id_instr[10:0];

    always_comb begin
        rd_rs  = 1'b0;
        rd_rt  = 1'b0;
        wr_en  = 1'b0;
        wr_reg = rd;
        is_br  = 1'b0;
        is_hlt = 1'b0;
        if (op <= 6'd5) begin
            rd_rs = 1'b1;
            rd_rt = 1'b1;
            wr_en = 1'b1;
        end else if (op == 6'b001000 || (op >= 6'b001010 && op <= 6'b001100)) begin
            rd_rs  = 1'b1;
            wr_en  = 1'b1;
            wr_reg = rt;
        end else if (op == 6'b001001) begin
            rd_rs = 1'b1;
            rd_rt = 1'b1;
        end else if (op == 6'b001101 || op == 6'b001110) begin
            rd_rs = 1'b1;
            is_br = 1'b1;
        end else if (op == 6'b111111) begin
            is_hlt = 1'b1;
        end
    end

    // pend_q[0] is held at zero, so R0 reads never see a hazard
    assign hazard = (rd_rs && rs != 5'd0 && pend_q[rs] != 2'd0) ||
                    (rd_rt && rt != 5'd0 && pend_q[rt] != 2'd0);

    assign issue       = id_valid & ~hazard & ~halted_q & (br_cnt_q == 2'd0);
    assign stall       = id_valid & ~issue;
    assign halted      = halted_q;
    assign stall_count = stall_count_q;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pend_d[i] = (pend_q[i] != 2'd0) ? pend_q[i] - 2'd1 : 2'd0;
        end
        // a fresh write restarts the count, overriding the decrement (WAW)
        if (issue && wr_en && wr_reg != 5'd0) begin
            pend_d[wr_reg] = WB_LOAD;
        end
        pend_d[0] = 2'd0;

        br_cnt_d = br_cnt_q;
        if (issue && is_br) begin
            br_cnt_d = BR_LOAD;
        end else if (br_cnt_q != 2'd0) begin
            br_cnt_d = br_cnt_q - 2'd1;
        end

        halted_d = halted_q | (issue & is_hlt);

        stall_count_d = stall_count_q;
        if (stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= 2'd0;
            end
            br_cnt_q      <= 2'd0;
            halted_q      <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= pend_d[i];
            end
            br_cnt_q      <= br_cnt_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed checks of hazard_scheduler at WB_DIST 2 and 3
module tb_hazard_scheduler;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        issue, stall, halted;
    logic [15:0] stall_count;
    logic        issue3, stall3, halted3;
    logic [15:0] stall_count3;

    int tests = 0;
    int fails = 0;

    always #5 clk1 = ~clk1;

    hazard_scheduler #(.WB_DIST(2), .BR_LAT(2)) dut (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .issue(issue), .stall(stall), .halted(halted), .stall_count(stall_count)
    );

    hazard_scheduler #(.WB_DIST(3), .BR_LAT(2)) dut3 (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .issue(issue3), .stall(stall3), .halted(halted3), .stall_count(stall_count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one ID slot just after the edge, leave time at the falling edge for checks
    task automatic cyc(input logic v, input logic [31:0] instr);
        @(posedge clk1);
        #1;
        id_valid = v;
        id_instr = instr;
        @(negedge clk1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
    endtask

    task automatic rst_pulse();
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        id_valid = 1'b1;
        id_instr = 32'h2801000a;
        #2;
        chk("rst_issue", issue, 1);
        chk("rst_stall", stall, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", stall_count, 0);
        chk("rst_count3", stall_count3, 0);
        id_valid = 1'b0;
        #1;
        rst_n = 1'b1;

        cyc(1'b1, 32'h2801000a); chk("indep_0", issue, 1);
        cyc(1'b1, 32'h28020014); chk("indep_1", issue, 1);
        cyc(1'b1, 32'h28030019); chk("indep_2", issue, 1);
        cyc(1'b0, 32'h0);        chk("indep_count", stall_count, 0);
        chk("idle_stall", stall, 0);
        idle(3);

        cyc(1'b1, 32'h2801000a); chk("raw_w", issue, 1);
        cyc(1'b1, 32'h00222000); chk("raw_stall", stall, 1);
        chk("raw_noissue", issue, 0);
        cyc(1'b1, 32'h00222000); chk("raw_issue", issue, 1);
        cyc(1'b0, 32'h0);        chk("raw_count", stall_count, 1);
        idle(3);

        cyc(1'b1, 32'h00222000); chk("gap_0", issue, 1);
        cyc(1'b1, 32'h0ce77800); chk("gap_1", issue, 1);
        cyc(1'b1, 32'h00832800); chk("gap_2", issue, 1);
        cyc(1'b0, 32'h0);        chk("gap_count", stall_count, 1);
        idle(3);

        rst_pulse();
        cyc(1'b1, 32'h2801000a); chk("wb3_w", issue3, 1);
        cyc(1'b1, 32'h00222000); chk("wb3_stall1", stall3, 1);
        cyc(1'b1, 32'h00222000); chk("wb3_stall2", stall3, 1);
        cyc(1'b1, 32'h00222000); chk("wb3_issue", issue3, 1);
        cyc(1'b0, 32'h0);        chk("wb3_count", stall_count3, 2);
        idle(3);

        rst_pulse();
        cyc(1'b1, 32'h34200000); chk("br_issue", issue, 1);
        cyc(1'b1, 32'h28050007); chk("br_stall1", stall, 1);
        cyc(1'b1, 32'h28050007); chk("br_stall2", stall, 1);
        cyc(1'b1, 32'h28050007); chk("br_release", issue, 1);
        cyc(1'b0, 32'h0);        chk("br_count", stall_count, 2);
        idle(3);

        rst_pulse();
        cyc(1'b1, 32'h2801000a); chk("hlt_pre", issue, 1);
        cyc(1'b1, 32'hfc000000); chk("hlt_issue", issue, 1);
        chk("hlt_not_yet", halted, 0);
        cyc(1'b1, 32'h28060001); chk("hlt_halted", halted, 1);
        chk("hlt_noissue", issue, 0);
        chk("hlt_stall", stall, 1);
        chk("hlt_count0", stall_count, 0);
        cyc(1'b1, 32'h28060001); chk("hlt_count1", stall_count, 1);
        cyc(1'b0, 32'h0);        chk("hlt_idle_stall", stall, 0);
        chk("hlt_count2", stall_count, 2);
        rst_n = 1'b0;
        #1;
        chk("hlt_rst_halted", halted, 0);
        chk("hlt_rst_count", stall_count, 0);
        rst_n = 1'b1;
        cyc(1'b1, 32'h28060001); chk("hlt_after_rst", issue, 1);

        cyc(1'b1, 32'h2801000a); chk("clr_w", issue, 1);
        cyc(1'b1, 32'h00222000); chk("clr_stall", stall, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("clr_in_rst_issue", issue, 1);
        chk("clr_in_rst_stall", stall, 0);
        rst_n = 1'b1;
        cyc(1'b1, 32'h00222000); chk("clr_after", issue, 1);
        idle(3);

        cyc(1'b1, 32'h28000005); chk("r0_w", issue, 1);
        cyc(1'b1, 32'h00001000); chk("r0_read", issue, 1);
        chk("r0_nostall", stall, 0);
        cyc(1'b1, 32'h00200800); chk("self_rw", issue, 1);
        cyc(1'b1, 32'h00200800); chk("self_pend", stall, 1);
        cyc(1'b1, 32'h00200800); chk("self_release", issue, 1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
